// File: rtl/jtkunio_pkg.sv
// Shared definitions for the Kunio scroll-layer scanner: map geometry,
// fetch FSM state encoding and the output pixel field layout.
// Optional feature macro (used by jtkunio_scr_scan): JTKUNIO_SCR_TILEFLIP_EN
package jtkunio_pkg;

  // Map: 64 columns x 16 rows of 16x16 tiles (1024 x 256 px)
  localparam int MAP_COL_W  = 6;
  localparam int MAP_ROW_W  = 4;
  localparam int TILE_ROW_W = 4;
  localparam int ROM_AW     = 17;
  localparam int PXL_W      = 6;

  // Fetch FSM encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_ATTR = 3'd2;
  localparam logic [2:0] ST_ROM  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Output pixel: palette on top, colour index below; all-zero is transparent
  typedef struct packed {
    logic [1:0] pal;
    logic [3:0] colour;
  } pxl_t;

  // Effective horizontal map position, wrapping at 1024
  function automatic logic [9:0] heff_calc(input logic [8:0] h,
                                           input logic [9:0] scr,
                                           input logic       fl);
    logic [8:0] hx;
    hx = fl ? ~h : h;
    return {1'b0, hx} + scr;
  endfunction

endpackage

// File: rtl/jtkunio_scr_shift.sv
// Eight-pixel, 4 bpp output shifter with selectable shift direction.
// The output pixel register lags the shifter by one pixel clock.
module jtkunio_scr_shift
  import jtkunio_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pxl_cen,
  input  logic             load,
  input  logic [31:0]      load_data,
  input  logic [1:0]       load_pal,
  input  logic             load_rev,
  output logic [PXL_W-1:0] pxl
);

  logic [31:0] shift_r;
  logic [1:0]  pal_r;
  logic        rev_r;
  pxl_t        pxl_r;
  logic [3:0]  head_s;
  logic [31:0] shifted_s;

  // Pick the pixel leaving the shifter and the advanced shifter contents
  always_comb begin
    head_s    = 4'd0;
    shifted_s = 32'd0;
    if (rev_r) begin
      head_s    = shift_r[31:28];
      shifted_s = {shift_r[27:0], 4'd0};
    end else begin
      head_s    = shift_r[3:0];
      shifted_s = {4'd0, shift_r[31:4]};
    end
  end

  // Advance or reload the shifter once per pixel clock
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r <= 32'd0;
      pal_r   <= 2'd0;
      rev_r   <= 1'b0;
      pxl_r   <= pxl_t'(6'd0);
    end else if (pxl_cen) begin
      pxl_r.pal    <= pal_r;
      pxl_r.colour <= head_s;
      if (load) begin
        shift_r <= load_data;
        pal_r   <= load_pal;
        rev_r   <= load_rev;
      end else begin
        shift_r <= shifted_s;
      end
    end
  end

  assign pxl = pxl_r;

endmodule

// File: rtl/jtkunio_scr_scan.sv
// Kunio scroll layer: tilemap scan, tile ROM fetch and pixel output.
// Each load event (pixel clock with heff[2:0]==0) hands the buffered
// 8-pixel word to the shifter and starts fetching the next group (heff+8).
// Optional feature macro: JTKUNIO_SCR_TILEFLIP_EN enables per-tile hflip
// from attribute bit 7; otherwise that bit is ignored.
module jtkunio_scr_scan
  import jtkunio_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pxl_cen,
  input  logic [8:0]        hdump,
  input  logic [7:0]        vdump,
  input  logic [9:0]        scrpos,
  input  logic              flip,
  output logic [9:0]        scan_addr,
  input  logic [15:0]       scan_dout,
  output logic              rom_cs,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              rom_ok,
  output logic [PXL_W-1:0]  pxl
);

  logic [2:0]                     state_r;
  logic [MAP_ROW_W+MAP_COL_W-1:0] scan_addr_r;
  logic                           rom_cs_r;
  logic [ROM_AW-1:0]              rom_addr_r;
  logic                           rom_arm_r;
  logic [TILE_ROW_W-1:0]          vrow_r;
  logic                           hsel_tgt_r;
  logic [1:0]                     pal_r;
  logic                           hflip_r;
  logic [31:0]                    buf_r;
  logic [1:0]                     buf_pal_r;
  logic                           buf_rev_r;
  logic                           buf_valid_r;

  logic [9:0]  heff_s;
  logic [9:0]  tgt_s;
  logic [7:0]  veff_s;
  logic        load_s;
  logic        tile_hflip_s;
  logic        unused_s;
  logic [31:0] sh_data_s;
  logic [1:0]  sh_pal_s;
  logic        sh_rev_s;

  assign heff_s = heff_calc(hdump, scrpos, flip);
  assign veff_s = flip ? ~vdump : vdump;
  assign tgt_s  = heff_s + 10'd8;
  assign load_s = pxl_cen && (heff_s[2:0] == 3'd0);

`ifdef JTKUNIO_SCR_TILEFLIP_EN
  assign tile_hflip_s = scan_dout[15];
  assign unused_s     = scan_dout[14];
`else
  assign tile_hflip_s = 1'b0;
  assign unused_s     = ^scan_dout[15:14];
`endif

  // Shifter gets the buffered word only if the fetch finished in time
  always_comb begin
    sh_data_s = 32'd0;
    sh_pal_s  = 2'd0;
    sh_rev_s  = 1'b0;
    if (buf_valid_r) begin
      sh_data_s = buf_r;
      sh_pal_s  = buf_pal_r;
      sh_rev_s  = buf_rev_r;
    end else begin
      sh_data_s = 32'd0;
      sh_pal_s  = 2'd0;
      sh_rev_s  = 1'b0;
    end
  end

  // Fetch sequencer: a load event always (re)starts a fetch for the next group
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      scan_addr_r <= 10'd0;
      rom_cs_r    <= 1'b0;
      rom_addr_r  <= 17'd0;
      rom_arm_r   <= 1'b0;
      vrow_r      <= 4'd0;
      hsel_tgt_r  <= 1'b0;
      pal_r       <= 2'd0;
      hflip_r     <= 1'b0;
      buf_r       <= 32'd0;
      buf_pal_r   <= 2'd0;
      buf_rev_r   <= 1'b0;
      buf_valid_r <= 1'b0;
    end else if (load_s) begin
      state_r     <= ST_RD;
      scan_addr_r <= {veff_s[7:4], tgt_s[9:4]};
      vrow_r      <= veff_s[3:0];
      hsel_tgt_r  <= tgt_s[3];
      rom_cs_r    <= 1'b0;
      rom_arm_r   <= 1'b0;
      buf_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: state_r <= ST_IDLE;
        ST_RD:   state_r <= ST_ATTR;
        ST_ATTR: begin
          pal_r      <= scan_dout[13:12];
          hflip_r    <= tile_hflip_s;
          rom_addr_r <= {scan_dout[11:0], vrow_r, hsel_tgt_r ^ tile_hflip_s};
          rom_cs_r   <= 1'b1;
          rom_arm_r  <= 1'b0;
          state_r    <= ST_ROM;
        end
        ST_ROM: begin
          // rom_ok only counts once the address has been held a full clock
          if (rom_arm_r && rom_ok) begin
            buf_r       <= rom_data;
            buf_pal_r   <= pal_r;
            buf_rev_r   <= flip ^ hflip_r;
            buf_valid_r <= 1'b1;
            rom_cs_r    <= 1'b0;
            state_r     <= ST_DONE;
          end else begin
            rom_arm_r <= 1'b1;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: begin
          state_r  <= ST_IDLE;
          rom_cs_r <= 1'b0;
        end
      endcase
    end
  end

  jtkunio_scr_shift u_shift (
    .clk       (clk),
    .rst       (rst),
    .pxl_cen   (pxl_cen),
    .load      (load_s),
    .load_data (sh_data_s),
    .load_pal  (sh_pal_s),
    .load_rev  (sh_rev_s),
    .pxl       (pxl)
  );

  assign scan_addr = scan_addr_r;
  assign rom_cs    = rom_cs_r;
  assign rom_addr  = rom_addr_r;

endmodule

// File: tb/tb_jtkunio_scr_scan.sv
// Directed bench for jtkunio_scr_scan with a tilemap RAM and tile ROM model.
// Honours JTKUNIO_SCR_TILEFLIP_EN for the per-tile hflip expectations.
module tb_jtkunio_scr_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        pxl_cen;
  logic [8:0]  hdump;
  logic [7:0]  vdump;
  logic [9:0]  scrpos;
  logic        flip;
  logic [9:0]  scan_addr;
  logic [15:0] scan_dout;
  logic        rom_cs;
  logic [16:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic [5:0]  pxl;

  int total = 0;
  int bad   = 0;
  int rom_delay = 2;

  logic [15:0] ram [0:1023];
  logic [16:0] rom_last;
  int          rom_cnt;

  typedef struct {
    logic [9:0]  scrpos;
    logic        flip;
    logic [7:0]  vdump;
    logic [8:0]  h0;
    logic [9:0]  exp_scan;
    logic [16:0] exp_rom;
    logic [31:0] exp_pix;
    logic [1:0]  exp_pal;
  } vec_t;
  vec_t vecs [0:5];

`ifdef JTKUNIO_SCR_TILEFLIP_EN
  localparam logic [16:0] V4_ROM = 17'h05C1F;
  localparam logic [31:0] V4_PIX = 32'hFEDCBA98;
  localparam logic [16:0] V5_ROM = 17'h05806;
  localparam logic [31:0] V5_PIX = 32'h01234567;
`else
  localparam logic [16:0] V4_ROM = 17'h05C1E;
  localparam logic [31:0] V4_PIX = 32'h01234567;
  localparam logic [16:0] V5_ROM = 17'h05807;
  localparam logic [31:0] V5_PIX = 32'hFEDCBA98;
`endif

  jtkunio_scr_scan dut (
    .clk       (clk),
    .rst       (rst),
    .pxl_cen   (pxl_cen),
    .hdump     (hdump),
    .vdump     (vdump),
    .scrpos    (scrpos),
    .flip      (flip),
    .scan_addr (scan_addr),
    .scan_dout (scan_dout),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rom_ok    (rom_ok),
    .pxl       (pxl)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [16:0] a);
    return a[0] ? 32'hFEDCBA98 : 32'h76543210;
  endfunction

  // Tilemap RAM model: one clock read latency
  always @(posedge clk) scan_dout <= ram[scan_addr];

  // Tile ROM model: rom_ok after the address has been steady rom_delay clocks
  always @(posedge clk) begin
    rom_last <= rom_addr;
    rom_data <= rom_word(rom_addr);
    if (rom_cs && rom_addr == rom_last) begin
      rom_cnt <= rom_cnt + 1;
      rom_ok  <= (rom_cnt >= rom_delay);
    end else begin
      rom_cnt <= 0;
      rom_ok  <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cen_edge();
    pxl_cen = 1'b1;
    @(posedge clk);
    #1;
    pxl_cen = 1'b0;
    hdump   = hdump + 9'd1;
  endtask

  task automatic gap();
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic pix();
    cen_edge();
    gap();
  endtask

  task automatic chk_pix(input string name, input logic [5:0] e);
    chk(name, {26'd0, pxl}, {26'd0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] e;
    int n;
    vecs[0] = '{10'h000, 1'b0, 8'h00, 9'h000, 10'h000, 17'h04681, 32'hFEDCBA98, 2'd1};
    vecs[1] = '{10'h000, 1'b0, 8'h00, 9'h008, 10'h001, 17'h04020, 32'h76543210, 2'd1};
    vecs[2] = '{10'h123, 1'b0, 8'h25, 9'h00D, 10'h093, 17'h0526B, 32'hFEDCBA98, 2'd1};
    vecs[3] = '{10'h000, 1'b1, 8'h10, 9'h007, 10'h3A0, 17'h0541E, 32'h01234567, 2'd1};
    vecs[4] = '{10'h000, 1'b1, 8'h00, 9'h007, 10'h3E0, V4_ROM,     V4_PIX,       2'd2};
    vecs[5] = '{10'h000, 1'b0, 8'hF3, 9'h000, 10'h3C0, V5_ROM,     V5_PIX,       2'd2};

    for (int a = 0; a < 1024; a++) begin
      logic [9:0] av;
      av = 10'(a);
      ram[a] = {(av[9:6] == 4'hF) ? 8'hE2 : 8'h12, av[7:0]};
    end
    ram[0] = 16'h1234;

    rst = 1'b1; pxl_cen = 1'b0; hdump = 9'd0; vdump = 8'd0; scrpos = 10'd0; flip = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_rom_cs", {31'd0, rom_cs}, 32'd0);
    chk("rst_rom_addr", {15'd0, rom_addr}, 32'd0);
    chk("rst_scan_addr", {22'd0, scan_addr}, 32'd0);
    chk_pix("rst_pxl", 6'd0);

    // Reset while the fetch sits in ROM wait
    rst = 1'b0; rom_delay = 1000;
    pix();
    n = 0;
    while (!rom_cs && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("rom_cs_up", {31'd0, rom_cs}, 32'd1);
    chk("first_rom_addr", {15'd0, rom_addr}, 32'h04681);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rom_cs", {31'd0, rom_cs}, 32'd0);
    chk("midrst_rom_addr", {15'd0, rom_addr}, 32'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; rom_delay = 2;
    // hdump 1..16: zeros (nothing valid loaded); 17..24: colours 0..7, palette 1
    for (int k = 1; k <= 24; k++) begin
      pix();
      e = (k <= 16) ? 6'd0 : {2'd1, 4'(k - 17)};
      chk_pix("after_rst_pxl", e);
    end

    // Table vectors: load at h0 starts fetch, load at h0+8 shows it
    for (int i = 0; i < 6; i++) begin
      scrpos = vecs[i].scrpos; flip = vecs[i].flip; vdump = vecs[i].vdump; hdump = vecs[i].h0;
      for (int k = 0; k < 17; k++) begin
        pix();
        if (k == 0) chk($sformatf("v%0d_scan", i), {22'd0, scan_addr}, {22'd0, vecs[i].exp_scan});
        if (k == 1) chk($sformatf("v%0d_rom", i), {15'd0, rom_addr}, {15'd0, vecs[i].exp_rom});
        if (k >= 9) begin
          e = {vecs[i].exp_pal, vecs[i].exp_pix[4*(k-9) +: 4]};
          chk_pix($sformatf("v%0d_pxl%0d", i, k - 9), e);
        end
      end
    end

    // Column wrap 63 -> 0 without gaps
    scrpos = 10'h3F0; flip = 1'b0; vdump = 8'd0; hdump = 9'd0;
    pix();
    chk("wrap_scan63", {22'd0, scan_addr}, 32'h03F);
    for (int k = 1; k <= 8; k++) pix();
    chk("wrap_scan0", {22'd0, scan_addr}, 32'h000);
    for (int j = 0; j < 16; j++) begin
      pix();
      if (j == 0) chk("wrap_rom0", {15'd0, rom_addr}, 32'h04680);
      e = (j < 8) ? {2'd1, 4'(8 + j)} : {2'd1, 4'(j - 8)};
      chk_pix("wrap_pxl", e);
    end

    // Late ROM: fetch abandoned at the next load, zeros shown, next group fine
    scrpos = 10'd0; hdump = 9'd0; rom_delay = 1000;
    for (int k = 0; k < 8; k++) pix();
    chk("late_rom_wait", {31'd0, rom_cs}, 32'd1);
    cen_edge();
    chk("late_restart_cs", {31'd0, rom_cs}, 32'd0);
    chk("late_restart_scan", {22'd0, scan_addr}, 32'h001);
    rom_delay = 2;
    gap();
    for (int k = 9; k <= 24; k++) begin
      pix();
      e = (k <= 16) ? 6'd0 : {2'd1, 4'(k - 17)};
      chk_pix("late_pxl", e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
